// File: rtl/keccak_shuffle_arbiter.sv
// Two-requester round-robin arbiter in front of a shared Keccak-f[1600] core,
// with optional halfword shuffling on the way in and out, and a watchdog on the core.
module keccak_shuffle_arbiter #(
    parameter bit SHUFFLE_IN  = 1'b1,
    parameter bit SHUFFLE_OUT = 1'b1,
    parameter int WDOG_CYCLES = 64
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_req0_valid,
    input  logic          i_req1_valid,
    input  logic [1599:0] i_req0_data,
    input  logic [1599:0] i_req1_data,
    output logic          o_req0_ready,
    output logic          o_req1_ready,
    output logic          o_core_start,
    output logic [1599:0] o_core_data,
    input  logic          i_core_done,
    input  logic [1599:0] i_core_data,
    output logic          o_rsp_valid,
    output logic [1599:0] o_rsp_data,
    output logic          o_rsp_id,
    output logic          o_rsp_err,
    input  logic          i_rsp_ready,
    output logic          o_busy
);

    localparam int CW = (WDOG_CYCLES > 1) ? $clog2(WDOG_CYCLES) : 1;
    localparam logic [CW-1:0] WDOG_LAST = CW'(WDOG_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    // Reverses the four halfwords inside every 64-bit lane; applying it twice is identity.
    function automatic logic [1599:0] shuffle(input logic [1599:0] s);
        logic [1599:0] r;
        r = '0;
        for (int k = 0; k < 25; k++) begin
            for (int h = 0; h < 4; h++) begin
                r[64*k + 16*h +: 16] = s[64*k + 16*(3-h) +: 16];
            end
        end
        return r;
    endfunction

    state_t          state;
    state_t          state_nx;
    logic            last_grant;
    logic            grant_id;
    logic            xfer;
    logic            timeout;
    logic [CW-1:0]   wdog_cnt;
    logic [1599:0]   core_reg;
    logic [1599:0]   rsp_reg;
    logic [1599:0]   sel_data;

    // NOTE: every signal driven here gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        state_nx     = state;
        o_req0_ready = 1'b0;
        o_req1_ready = 1'b0;
        xfer         = 1'b0;
        timeout      = 1'b0;
        grant_id     = (i_req0_valid && i_req1_valid) ? ~last_grant : i_req1_valid;
        sel_data     = grant_id ? i_req1_data : i_req0_data;

        case (state)
            IDLE: begin
                if ((i_req0_valid || i_req1_valid) && !i_rst) begin
                    o_req0_ready = ~grant_id;
                    o_req1_ready = grant_id;
                    xfer         = 1'b1;
                    state_nx     = START;
                end
            end
            START: state_nx = WAIT;
            WAIT: begin
                if (i_core_done) begin
                    state_nx = RESP;
                end else if (wdog_cnt == WDOG_LAST) begin
                    timeout  = 1'b1;
                    state_nx = RESP;
                end
            end
            RESP: begin
                if (i_rsp_ready) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
    always_ff @(posedge i_clk) begin
        if (i_rst) state <= IDLE;
        else       state <= state_nx;
    end

    // NOTE: the wide data registers are cleared on reset too, so no stale state leaks onto the outputs.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            last_grant <= 1'b1;
            wdog_cnt   <= '0;
            core_reg   <= '0;
            rsp_reg    <= '0;
            o_rsp_id   <= 1'b0;
            o_rsp_err  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (xfer) begin
                        core_reg   <= SHUFFLE_IN ? shuffle(sel_data) : sel_data;
                        o_rsp_id   <= grant_id;
                        last_grant <= grant_id;
                    end
                end
                START: wdog_cnt <= '0;
                WAIT: begin
                    wdog_cnt <= wdog_cnt + 1'b1;
                    if (i_core_done) begin
                        rsp_reg   <= SHUFFLE_OUT ? shuffle(i_core_data) : i_core_data;
                        o_rsp_err <= 1'b0;
                    end else if (timeout) begin
                        rsp_reg   <= '0;
                        o_rsp_err <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign o_core_start = (state == START);
    assign o_core_data  = core_reg;
    assign o_rsp_valid  = (state == RESP);
    assign o_rsp_data   = rsp_reg;
    assign o_busy       = (state != IDLE);

endmodule

// File: tb/tb_keccak_shuffle_arbiter.sv
// Randomized self-checking bench: instance 0 uses defaults, instance 1 has no shuffling
// and an 8-cycle watchdog; a transaction-level model predicts grants and data.
module tb_keccak_shuffle_arbiter;

    localparam int W = 1600;

    logic         clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst         [2];
    logic         req_valid   [2][2];
    logic [W-1:0] req_data    [2][2];
    logic         req_ready   [2][2];
    logic         core_start  [2];
    logic [W-1:0] core_data_o [2];
    logic         core_done   [2];
    logic [W-1:0] core_data_i [2];
    logic         rsp_valid   [2];
    logic [W-1:0] rsp_data    [2];
    logic         rsp_id      [2];
    logic         rsp_err     [2];
    logic         rsp_ready   [2];
    logic         busy        [2];

    keccak_shuffle_arbiter #(.SHUFFLE_IN(1'b1), .SHUFFLE_OUT(1'b1), .WDOG_CYCLES(64)) u_dut0 (
        .i_clk(clk), .i_rst(rst[0]),
        .i_req0_valid(req_valid[0][0]), .i_req1_valid(req_valid[0][1]),
        .i_req0_data(req_data[0][0]), .i_req1_data(req_data[0][1]),
        .o_req0_ready(req_ready[0][0]), .o_req1_ready(req_ready[0][1]),
        .o_core_start(core_start[0]), .o_core_data(core_data_o[0]),
        .i_core_done(core_done[0]), .i_core_data(core_data_i[0]),
        .o_rsp_valid(rsp_valid[0]), .o_rsp_data(rsp_data[0]),
        .o_rsp_id(rsp_id[0]), .o_rsp_err(rsp_err[0]),
        .i_rsp_ready(rsp_ready[0]), .o_busy(busy[0])
    );

    keccak_shuffle_arbiter #(.SHUFFLE_IN(1'b0), .SHUFFLE_OUT(1'b0), .WDOG_CYCLES(8)) u_dut1 (
        .i_clk(clk), .i_rst(rst[1]),
        .i_req0_valid(req_valid[1][0]), .i_req1_valid(req_valid[1][1]),
        .i_req0_data(req_data[1][0]), .i_req1_data(req_data[1][1]),
        .o_req0_ready(req_ready[1][0]), .o_req1_ready(req_ready[1][1]),
        .o_core_start(core_start[1]), .o_core_data(core_data_o[1]),
        .i_core_done(core_done[1]), .i_core_data(core_data_i[1]),
        .o_rsp_valid(rsp_valid[1]), .o_rsp_data(rsp_data[1]),
        .o_rsp_id(rsp_id[1]), .o_rsp_err(rsp_err[1]),
        .i_rsp_ready(rsp_ready[1]), .o_busy(busy[1])
    );

    int checks   = 0;
    int failures = 0;

    bit cfg_sin [2] = '{1'b1, 1'b0};
    bit cfg_sout[2] = '{1'b1, 1'b0};
    int cfg_wd  [2] = '{64, 8};
    bit mdl_last[2];

    task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h expected=%h (low 64 bits)", tag, got[63:0], exp[63:0]);
        end
    endtask

    function automatic logic [W-1:0] ref_shuffle(input logic [W-1:0] s);
        logic [W-1:0] r;
        logic [63:0]  ln;
        r = '0;
        for (int k = 0; k < 25; k++) begin
            ln = s[64*k +: 64];
            r[64*k +: 64] = {ln[15:0], ln[31:16], ln[47:32], ln[63:48]};
        end
        return r;
    endfunction

    function automatic logic [W-1:0] rand_state();
        logic [W-1:0] r;
        for (int k = 0; k < 50; k++) r[32*k +: 32] = $urandom;
        return r;
    endfunction

    // Outputs must all be zero while reset is applied, even with requests pending.
    task automatic reset_dut(input int d);
        rst[d] = 1'b1;
        req_valid[d][0] = 1'b1;
        req_valid[d][1] = 1'b1;
        @(negedge clk);
        #1;
        check("rst_ready0", req_ready[d][0], 0);
        check("rst_ready1", req_ready[d][1], 0);
        check("rst_start", core_start[d], 0);
        check("rst_core_data", core_data_o[d], '0);
        check("rst_rsp_valid", rsp_valid[d], 0);
        check("rst_rsp_data", rsp_data[d], '0);
        check("rst_rsp_id", rsp_id[d], 0);
        check("rst_rsp_err", rsp_err[d], 0);
        check("rst_busy", busy[d], 0);
        rst[d] = 1'b0;
        req_valid[d][0] = 1'b0;
        req_valid[d][1] = 1'b0;
        mdl_last[d] = 1'b1;
    endtask

    // One full job, entered at a negedge in IDLE. lat = cycles from start to done
    // (done is suppressed if the watchdog fires first); bp = cycles of backpressure;
    // late_done = RESP cycle in which a stray done is injected (-1 for none).
    task automatic do_txn(input int d, input bit v0, input bit v1, input int lat,
                          input int bp, input bit echo, input int late_done);
        bit           exp_id;
        bit           exp_err;
        logic [W-1:0] exp_core;
        logic [W-1:0] core_val;
        logic [W-1:0] exp_rsp;
        int           wait_n;

        req_valid[d][0] = v0;
        req_valid[d][1] = v1;
        #1;
        exp_id = (v0 && v1) ? !mdl_last[d] : v1;
        check("grant_ready0", req_ready[d][0], (exp_id == 1'b0));
        check("grant_ready1", req_ready[d][1], (exp_id == 1'b1));
        exp_core = cfg_sin[d] ? ref_shuffle(req_data[d][exp_id]) : req_data[d][exp_id];
        mdl_last[d] = exp_id;

        @(negedge clk);
        check("start_pulse", core_start[d], 1);
        check("core_data", core_data_o[d], exp_core);
        check("start_ready0", req_ready[d][0], 0);
        check("start_ready1", req_ready[d][1], 0);
        check("start_busy", busy[d], 1);

        wait_n   = (lat <= cfg_wd[d]) ? lat : cfg_wd[d];
        core_val = echo ? exp_core : rand_state();
        for (int i = 1; i <= wait_n; i++) begin
            @(negedge clk);
            check("start_once", core_start[d], 0);
            check("core_hold", core_data_o[d], exp_core);
            check("no_early_rsp", rsp_valid[d], 0);
            if (i == lat) begin
                core_done[d]   = 1'b1;
                core_data_i[d] = core_val;
            end
        end
        @(negedge clk);
        core_done[d]   = 1'b0;
        core_data_i[d] = rand_state();

        exp_err = (lat > cfg_wd[d]);
        exp_rsp = exp_err ? '0 : (cfg_sout[d] ? ref_shuffle(core_val) : core_val);
        for (int b = 0; b <= bp; b++) begin
            rsp_ready[d] = (b == bp);
            if (b == late_done) begin
                core_done[d]   = 1'b1;
                core_data_i[d] = rand_state();
            end
            #1;
            check("rsp_valid", rsp_valid[d], 1);
            check("rsp_data", rsp_data[d], exp_rsp);
            check("rsp_id", rsp_id[d], exp_id);
            check("rsp_err", rsp_err[d], exp_err);
            check("rsp_ready0", req_ready[d][0], 0);
            check("rsp_ready1", req_ready[d][1], 0);
            @(negedge clk);
            core_done[d] = 1'b0;
        end
        rsp_ready[d] = 1'b0;
        check("idle_busy", busy[d], 0);
        check("idle_rsp_valid", rsp_valid[d], 0);
    endtask

    // A done pulse while idle must not create a response.
    task automatic stray_done(input int d);
        req_valid[d][0] = 1'b0;
        req_valid[d][1] = 1'b0;
        core_done[d]    = 1'b1;
        core_data_i[d]  = rand_state();
        @(negedge clk);
        core_done[d] = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("stray_no_rsp", rsp_valid[d], 0);
            check("stray_busy", busy[d], 0);
            @(negedge clk);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout got=running expected=finished");
        $fatal(1);
    end

    initial begin
        bit v0;
        bit v1;
        for (int d = 0; d < 2; d++) begin
            rst[d] = 1'b1;
            req_valid[d][0] = 1'b0;
            req_valid[d][1] = 1'b0;
            req_data[d][0]  = rand_state();
            req_data[d][1]  = rand_state();
            core_done[d]    = 1'b0;
            core_data_i[d]  = '0;
            rsp_ready[d]    = 1'b0;
        end
        reset_dut(0);
        reset_dut(1);

        // Tie right after reset: req0 first, then strict alternation.
        for (int n = 0; n < 4; n++) begin
            req_data[0][0] = rand_state();
            req_data[0][1] = rand_state();
            do_txn(0, 1'b1, 1'b1, $urandom_range(1, 6), 0, 1'b0, -1);
        end

        // Single request, echoing core, 24-cycle core latency.
        req_data[0][0] = {25{64'h0123_4567_89AB_CDEF}};
        do_txn(0, 1'b1, 1'b0, 24, 0, 1'b1, -1);

        // Long backpressure on the response.
        req_data[0][1] = rand_state();
        do_txn(0, 1'b0, 1'b1, 5, 10, 1'b0, -1);

        // Reset pulse in the middle of WAIT, then a late done.
        req_data[0][0]  = rand_state();
        req_valid[0][0] = 1'b1;
        req_valid[0][1] = 1'b0;
        @(negedge clk);
        req_valid[0][0] = 1'b0;
        repeat (4) @(negedge clk);
        rst[0] = 1'b1;
        @(negedge clk);
        rst[0] = 1'b0;
        mdl_last[0] = 1'b1;
        check("mid_rst_busy", busy[0], 0);
        stray_done(0);
        req_data[0][0] = rand_state();
        req_data[0][1] = rand_state();
        do_txn(0, 1'b1, 1'b1, 7, 1, 1'b0, -1);

        // Randomized traffic on the default instance.
        for (int n = 0; n < 16; n++) begin
            v0 = $urandom_range(0, 1);
            v1 = v0 ? 1'($urandom_range(0, 1)) : 1'b1;
            req_data[0][0] = rand_state();
            req_data[0][1] = rand_state();
            do_txn(0, v0, v1, $urandom_range(1, 30), $urandom_range(0, 3), 1'($urandom_range(0, 1)), -1);
        end

        // Unshuffled instance: pass-through, done/timeout boundary, watchdog abort.
        req_data[1][0] = rand_state();
        do_txn(1, 1'b1, 1'b0, 3, 0, 1'b0, -1);
        req_data[1][1] = rand_state();
        do_txn(1, 1'b0, 1'b1, 8, 0, 1'b0, -1);
        req_data[1][0] = rand_state();
        do_txn(1, 1'b1, 1'b0, 9, 0, 1'b0, -1);
        req_data[1][1] = rand_state();
        do_txn(1, 1'b1, 1'b1, 100, 5, 1'b0, 3);
        stray_done(1);
        for (int n = 0; n < 8; n++) begin
            v0 = $urandom_range(0, 1);
            v1 = v0 ? 1'($urandom_range(0, 1)) : 1'b1;
            req_data[1][0] = rand_state();
            req_data[1][1] = rand_state();
            do_txn(1, v0, v1, $urandom_range(1, 12), $urandom_range(0, 2), 1'b0, $urandom_range(0, 2));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/keccak_shuffle_arbiter.md
KECCAK_SHUFFLE_ARBITER -- requirements
Module: keccak_shuffle_arbiter

Interface
REQ-001 Parameter SHUFFLE_IN, default 1: when 1, request data is halfword-shuffled before it goes to the core.
REQ-002 Parameter SHUFFLE_OUT, default 1: when 1, core result is halfword-shuffled before it is returned.
REQ-003 Parameter WDOG_CYCLES, default 64: maximum number of WAIT cycles before the request aborts.
REQ-004 i_clk  input  1  single clock; all logic rising-edge.
REQ-005 i_rst  input  1  synchronous, active-high reset.
REQ-006 i_req0_valid / i_req1_valid  input  1 each  requester has a state pending.
REQ-007 i_req0_data / i_req1_data  input  1600 each  requester Keccak state.
REQ-008 o_req0_ready / o_req1_ready  output  1 each  grant and accept strobe.
REQ-009 o_core_start  output  1  one-cycle start pulse to the shared Keccak-f[1600] core.
REQ-010 o_core_data  output  1600  core input state.
REQ-011 i_core_done  input  1  one-cycle completion pulse from the core.
REQ-012 i_core_data  input  1600  core output state; valid while i_core_done=1.
REQ-013 o_rsp_valid  output  1  response pending.
REQ-014 o_rsp_data  output  1600  result state.
REQ-015 o_rsp_id  output  1  index of the served requester.
REQ-016 o_rsp_err  output  1  response was produced by a watchdog abort.
REQ-017 i_rsp_ready  input  1  response consumer accepts.
REQ-018 o_busy  output  1  high in every state except IDLE.

Function
REQ-019 Shuffle definition: for each 64-bit lane k (0..24), the output halfwords are lane bits [15:0]<-[63:48], [31:16]<-[47:32], [47:32]<-[31:16], [63:48]<-[15:0]. The function is an involution.
REQ-020 FSM states: IDLE, START, WAIT, RESP; sole transition sources are listed below.
REQ-021 In IDLE, o_reqN_ready is combinationally 1 only for the granted requester N; a transfer occurs when valid and ready are both 1.
REQ-022 Grant rule: a single valid request wins; on a tie, the requester that is not last_grant wins (round-robin).
REQ-023 On transfer: latch data (shuffled if SHUFFLE_IN) into the core register, record the id, set last_grant to the id, then go to START.
REQ-024 START: o_core_start=1 for exactly one cycle, then go to WAIT.
REQ-025 o_core_data is driven from the core register and stays stable from START until the state leaves WAIT.
REQ-026 WAIT: the watchdog counter clears on entry and increments each cycle.
REQ-027 In WAIT, i_core_done=1 latches i_core_data (shuffled if SHUFFLE_OUT) into the response register, sets o_rsp_err=0, and moves to RESP.
REQ-028 In WAIT, when the counter reaches WDOG_CYCLES-1 without done, set o_rsp_err=1, set response data to all zeros, and move to RESP; if done and timeout occur in the same cycle, done wins.
REQ-029 RESP: o_rsp_valid=1, with o_rsp_data, o_rsp_id and o_rsp_err held stable until i_rsp_ready=1, then go to IDLE.
REQ-030 A requester whose valid is seen in IDLE while in RESP is not granted until the next IDLE cycle.
REQ-031 i_core_done outside WAIT is ignored; in particular, a late done after a timeout produces no second response.
REQ-032 Latency: transfer in cycle T, o_core_start in T+1, done at D >= T+2, o_rsp_valid from D+1.
REQ-033 Minimum turnaround is one IDLE cycle between a response handshake and the next grant.
REQ-034 o_reqN_ready is 0 in every non-IDLE state; requesters must hold valid and data until ready.

Reset
REQ-035 While i_rst=1 at a clock edge: state=IDLE, last_grant=1 (so req0 wins the first tie), all outputs 0, and the data registers cleared to zero.
REQ-036 Reset asserted mid-operation (START, WAIT or RESP) aborts the job; the in-flight state is dropped, and any core done arriving after reset is ignored per REQ-031.
REQ-037 In the first cycle after reset deassertion the block is in IDLE and may grant.

Verification
REQ-038 Single request: req0 data=lane pattern 64'h0123_4567_89AB_CDEF repeated, core model echoes input after 24 cycles -> o_core_data lanes=64'hCDEF_89AB_4567_0123; o_rsp_data equals the original request; o_rsp_id=0; o_rsp_err=0; rsp_valid at T+26.
REQ-039 Tie after reset: both valid together -> req0 served first, then req1; with both kept asserted, the grants alternate 0,1,0,1.
REQ-040 Watchdog with WDOG_CYCLES=8 and the core never finishing -> RESP after 8 WAIT cycles; o_rsp_err=1; o_rsp_data=0; a done injected 3 cycles later causes no extra response.
REQ-041 Backpressure: i_rsp_ready held 0 for 10 cycles -> o_rsp_valid/o_rsp_data stable and both o_reqN_ready stay 0; a single response is accepted when ready rises.
REQ-042 Reset in WAIT: i_rst pulsed 1 cycle mid-WAIT, then core done -> no response, o_busy=0, and the next request is served normally.
REQ-043 SHUFFLE_IN=0, SHUFFLE_OUT=0 -> o_core_data equals the request data bit-for-bit, and the response equals i_core_data.
